iob_cache: RTL and testbench

IOB_CACHE -- requirements
Module: iob_cache

---
 rtl/iob_cache.sv | 246 ++++++++++++++++++++++++
 tb/tb_iob_cache.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache.sv
// Direct-mapped, write-through, no-write-allocate cache between a simple
// valid/ready CPU port and a valid/ready memory port. The control space
// (addr MSB set) reads the hit/miss counters or invalidates all lines.
module iob_cache #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 16,
  parameter int MEM_DATA_W = 32,
  parameter int NLINE_W    = 4,
  parameter int WORD_OFF_W = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ADDR_W-$clog2(DATA_W/8):0]     addr,
  input  logic [DATA_W-1:0]                    wdata,
  input  logic [DATA_W/8-1:0]                  wstrb,
  input  logic                                 valid,
  output logic [DATA_W-1:0]                    rdata,
  output logic                                 ready,
  output logic [1:0]                           debug,
  output logic [MEM_ADDR_W-1:0]                mem_addr,
  output logic [MEM_DATA_W-1:0]                mem_wdata,
  output logic [MEM_DATA_W/8-1:0]              mem_wstrb,
  input  logic [MEM_DATA_W-1:0]                mem_rdata,
  output logic                                 mem_valid,
  input  logic                                 mem_ready
);

  localparam int BYTE_OFF_W     = $clog2(DATA_W/8);
  localparam int WADDR_W        = ADDR_W - BYTE_OFF_W;
  localparam int TAG_W          = WADDR_W - NLINE_W - WORD_OFF_W;
  localparam int N_LINES        = 1 << NLINE_W;
  localparam int N_WORDS        = 1 << WORD_OFF_W;
  localparam int MEM_N_BYTES    = MEM_DATA_W / 8;
  localparam int MEM_BYTE_OFF_W = $clog2(MEM_N_BYTES);
  localparam int CNT_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FILL,
    S_WRITE,
    S_REPLY
  } state_t;

  // Request address fields
  logic                  sel;
  logic [WADDR_W-1:0]    waddr;
  logic [TAG_W-1:0]      tag;
  logic [NLINE_W-1:0]    idx;
  logic [WORD_OFF_W-1:0] woff;

  assign sel   = addr[WADDR_W];
  assign waddr = addr[WADDR_W-1:0];
  assign tag   = waddr[WADDR_W-1 -: TAG_W];
  assign idx   = waddr[WORD_OFF_W +: NLINE_W];
  assign woff  = waddr[WORD_OFF_W-1:0];

  // Registered state and outputs
  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [1:0]              debug_q, debug_d;
  logic                    mem_valid_q, mem_valid_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [MEM_DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MEM_N_BYTES-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic [WORD_OFF_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;
  logic [N_LINES-1:0]      line_valid_q, line_valid_d;

  // Storage arrays and their write port
  logic [DATA_W-1:0]               data_mem [N_LINES*N_WORDS];
  logic [TAG_W-1:0]                tag_mem  [N_LINES];
  logic                            dm_we;
  logic [NLINE_W+WORD_OFF_W-1:0]   dm_addr;
  logic [DATA_W-1:0]               dm_wdata;
  logic [DATA_W/8-1:0]             dm_be;
  logic                            tag_we;

  logic                            hit;
  logic [DATA_W-1:0]               rd_word;
  logic [MEM_ADDR_W-1:0]           line_word_addr;

  assign hit            = line_valid_q[idx] && (tag_mem[idx] == tag);
  assign rd_word        = data_mem[{idx, woff}];
  assign line_word_addr = MEM_ADDR_W'({tag, idx, fill_cnt_q, {MEM_BYTE_OFF_W{1'b0}}});

  // Next-state, output and array-write decode for the request FSM
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d      = state_q;
    ready_d      = 1'b0;
    rdata_d      = rdata_q;
    debug_d      = 2'b00;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    fill_cnt_d   = fill_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    line_valid_d = line_valid_q;
    dm_we        = 1'b0;
    dm_addr      = {idx, woff};
    dm_wdata     = wdata;
    dm_be        = wstrb;
    tag_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          if (sel) begin
            // Control space answers in one cycle without touching memory
            state_d = S_REPLY;
            ready_d = 1'b1;
            if (wstrb != '0) line_valid_d = '0;
            else rdata_d = DATA_W'({miss_cnt_q, hit_cnt_q});
          end else if (wstrb != '0) begin
            state_d     = S_WRITE;
            mem_valid_d = 1'b1;
            mem_addr_d  = MEM_ADDR_W'({waddr, {MEM_BYTE_OFF_W{1'b0}}});
            mem_wdata_d = MEM_DATA_W'(wdata);
            mem_wstrb_d = MEM_N_BYTES'(wstrb);
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        if (hit) begin
          state_d   = S_REPLY;
          ready_d   = 1'b1;
          rdata_d   = rd_word;
          debug_d   = 2'b01;
          hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
        end else begin
          state_d     = S_FILL;
          debug_d     = 2'b10;
          miss_cnt_d  = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
          fill_cnt_d  = '0;
          mem_valid_d = 1'b1;
          mem_addr_d  = MEM_ADDR_W'({tag, idx, {WORD_OFF_W{1'b0}}, {MEM_BYTE_OFF_W{1'b0}}});
          mem_wstrb_d = '0;
        end
      end

      S_FILL: begin
        if (mem_valid_q && mem_ready) begin
          mem_valid_d = 1'b0;
          dm_we       = 1'b1;
          dm_addr     = {idx, fill_cnt_q};
          dm_wdata    = DATA_W'(mem_rdata);
          dm_be       = '1;
          // Capture the requested word as it streams past
          if (fill_cnt_q == woff) rdata_d = DATA_W'(mem_rdata);
          if (fill_cnt_q == '1) begin
            tag_we            = 1'b1;
            line_valid_d[idx] = 1'b1;
            state_d           = S_REPLY;
            ready_d           = 1'b1;
          end else begin
            fill_cnt_d = fill_cnt_q + WORD_OFF_W'(1);
          end
        end else if (!mem_valid_q) begin
          // One idle cycle after each completion, then fetch the next word
          mem_valid_d = 1'b1;
          mem_addr_d  = line_word_addr;
        end
      end

      S_WRITE: begin
        if (mem_valid_q && mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = S_REPLY;
          ready_d     = 1'b1;
          dm_we       = hit;
        end
      end

      S_REPLY: begin
        // Host drops valid during this cycle; do not re-accept it
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      debug_q      <= 2'b00;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      fill_cnt_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      line_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      debug_q      <= debug_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      fill_cnt_q   <= fill_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      line_valid_q <= line_valid_d;
    end
  end

  // Data and tag arrays with byte-enabled writes
  always_ff @(posedge clk) begin
    // NOTE: the arrays are not reset; line_valid_q guards against stale
    // contents, which keeps these mappable to plain RAM.
    if (dm_we && !reset) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (dm_be[b]) data_mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
    end
    if (tag_we && !reset) tag_mem[idx] <= tag;
  end

  // Handshake outputs are forced quiet for as long as reset is held
  assign ready     = ready_q & ~reset;
  assign rdata     = reset ? '0 : rdata_q;
  assign debug     = reset ? 2'b00 : debug_q;
  assign mem_valid = mem_valid_q & ~reset;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_iob_cache.sv
// Scoreboard bench for iob_cache: a behavioural cache/memory model predicts
// memory transactions and CPU responses; separate monitor and memory
// responder processes pop and compare them as the DUT presents them.
module tb_iob_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        valid;
  logic [31:0] rdata;
  logic        ready;
  logic [1:0]  debug;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_ready;

  always #5 clk = ~clk;

  iob_cache dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .valid     (valid),
    .rdata     (rdata),
    .ready     (ready),
    .debug     (debug),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  typedef struct {
    logic [31:0] rdata;
    bit          chk_data;
    logic [1:0]  dbg;
  } rsp_t;

  typedef struct {
    logic [15:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mtx_t;

  rsp_t exp_rsp_q[$];
  mtx_t exp_mem_q[$];

  // Behavioural reference: backing memory plus per-line valid/tag and counters
  logic [31:0] ref_mem [logic [13:0]];
  bit   [15:0] m_valid;
  logic [7:0]  m_tag [16];
  int          m_hits;
  int          m_misses;

  function automatic logic [31:0] mem_word(input logic [13:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'(w) * 32'h9E37_79B1 + 32'h1357_2468;
  endfunction

  task automatic model_reset();
    m_valid  = '0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Predict everything one request will cause; returns the exact CPU latency
  // in cycles where it is fixed, otherwise -1.
  task automatic model_issue(input bit sel, input logic [13:0] w,
                             input logic [31:0] wd, input logic [3:0] ws,
                             output int exp_lat);
    rsp_t        r;
    mtx_t        m;
    logic [3:0]  li;
    logic [31:0] cur;
    logic [1:0]  kk;
    r.rdata    = '0;
    r.chk_data = 1'b0;
    r.dbg      = 2'b00;
    exp_lat    = -1;
    li         = w[5:2];
    if (sel) begin
      exp_lat = 1;
      if (ws != 0) begin
        m_valid = '0;
      end else begin
        r.rdata    = {m_misses[15:0], m_hits[15:0]};
        r.chk_data = 1'b1;
      end
    end else if (ws != 0) begin
      m.addr  = {w, 2'b00};
      m.we    = 1'b1;
      m.wdata = wd;
      m.wstrb = ws;
      exp_mem_q.push_back(m);
      cur = mem_word(w);
      for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
      ref_mem[w] = cur;
    end else begin
      if (m_valid[li] && m_tag[li] == w[13:6]) begin
        if (m_hits < 65535) m_hits++;
        r.dbg   = 2'b01;
        exp_lat = 2;
      end else begin
        for (int k = 0; k < 4; k++) begin
          kk      = k[1:0];
          m.addr  = {w[13:2], kk, 2'b00};
          m.we    = 1'b0;
          m.wdata = '0;
          m.wstrb = '0;
          exp_mem_q.push_back(m);
        end
        m_valid[li] = 1'b1;
        m_tag[li]   = w[13:6];
        if (m_misses < 65535) m_misses++;
        r.dbg = 2'b10;
      end
      r.rdata    = mem_word(w);
      r.chk_data = 1'b1;
    end
    exp_rsp_q.push_back(r);
  endtask

  // Issue one CPU request and wait (bounded) for its ready pulse
  task automatic do_req(input bit sel, input logic [13:0] w,
                        input logic [31:0] wd, input logic [3:0] ws);
    int exp_lat;
    int cycles;
    model_issue(sel, w, wd, ws, exp_lat);
    addr   = {sel, w};
    wdata  = wd;
    wstrb  = ws;
    valid  = 1'b1;
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (ready) break;
      if (cycles >= 200) begin
        fail_now("ready_timeout");
        break;
      end
    end
    valid = 1'b0;
    if (exp_lat > 0) check("latency", 64'(cycles), 64'(exp_lat));
    @(negedge clk);
  endtask

  // CPU-side monitor: pops an expected response at every ready pulse
  int n_hit_p  = 0;
  int n_miss_p = 0;

  initial begin : cpu_monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      n_hit_p  += int'(debug[0]);
      n_miss_p += int'(debug[1]);
      if (ready) begin
        if (exp_rsp_q.size() == 0) begin
          fail_now("unexpected_ready");
        end else begin
          r = exp_rsp_q.pop_front();
          if (r.chk_data) check("rdata", 64'(rdata), 64'(r.rdata));
          check("debug_hit_pulses", 64'(n_hit_p), 64'(r.dbg[0]));
          check("debug_miss_pulses", 64'(n_miss_p), 64'(r.dbg[1]));
        end
        n_hit_p  = 0;
        n_miss_p = 0;
      end
    end
  end

  // Memory responder/monitor: random latency, spurious ready while idle
  initial begin : mem_responder
    int          lat;
    logic [15:0] held;
    mtx_t        e;
    lat       = -1;
    held      = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (reset) begin
        lat = -1;
      end else if (mem_valid) begin
        if (lat < 0) begin
          lat  = $urandom_range(0, 3);
          held = mem_addr;
        end
        if (lat == 0) begin
          check("mem_addr_hold", 64'(mem_addr), 64'(held));
          if (exp_mem_q.size() == 0) begin
            fail_now("unexpected_mem_transfer");
          end else begin
            e = exp_mem_q.pop_front();
            check("mem_addr", 64'(mem_addr), 64'(e.addr));
            check("mem_wstrb", 64'(mem_wstrb), e.we ? 64'(e.wstrb) : 64'd0);
            if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
            else mem_rdata = mem_word(mem_addr[15:2]);
          end
          mem_ready = 1'b1;
          lat       = -1;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int          lat;
    int          op;
    logic [13:0] w;
    logic [7:0]  t;
    logic [3:0]  li;
    logic [1:0]  wo;
    reset = 1'b1;
    valid = 1'b0;
    addr  = '0;
    wdata = '0;
    wstrb = '0;
    model_reset();

    repeat (5) begin
      @(negedge clk);
      check("reset_outputs", {28'd0, ready, mem_valid, debug, rdata}, 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Directed sequence on word address 0x1234
    do_req(1'b0, 14'h1234, 32'hDEAD_BEEF, 4'hF);
    do_req(1'b0, 14'h1234, 32'h0, 4'h0);
    check("cold_read_rdata", 64'(rdata), 64'h0000_0000_DEAD_BEEF);
    do_req(1'b0, 14'h1234, 32'h0, 4'h0);
    check("hit_read_rdata", 64'(rdata), 64'h0000_0000_DEAD_BEEF);
    do_req(1'b0, 14'h1234, 32'h0000_00AA, 4'h1);
    do_req(1'b0, 14'h1234, 32'h0, 4'h0);
    check("partial_write_rdata", 64'(rdata), 64'h0000_0000_DEAD_BEAA);
    do_req(1'b1, 14'h0, 32'h0, 4'h0);
    check("ctrl_counters", 64'(rdata), 64'h0000_0000_0001_0002);
    do_req(1'b1, 14'h0, 32'h0, 4'hF);
    do_req(1'b0, 14'h1234, 32'h0, 4'h0);

    // Reset in the middle of a line fill
    model_issue(1'b0, 14'h0A05, 32'h0, 4'h0, lat);
    addr  = {1'b0, 14'h0A05};
    wstrb = 4'h0;
    valid = 1'b1;
    for (int i = 0; i < 20 && !mem_valid; i++) @(negedge clk);
    check("fill_started", 64'(mem_valid), 64'd1);
    reset = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("reset_mid_fill", {59'd0, ready, mem_valid, debug, 1'b0}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold_outputs", {28'd0, ready, mem_valid, debug, rdata}, 64'd0);
    end
    exp_rsp_q.delete();
    exp_mem_q.delete();
    model_reset();
    reset = 1'b0;
    @(negedge clk);
    n_hit_p  = 0;
    n_miss_p = 0;
    do_req(1'b0, 14'h1234, 32'h0, 4'h0);
    do_req(1'b1, 14'h0, 32'h0, 4'h0);
    check("ctrl_after_reset", 64'(rdata), 64'h0000_0000_0001_0000);

    // Randomized traffic over a few tags so lines both hit and conflict
    for (int n = 0; n < 150; n++) begin
      t  = 8'h48 + 8'($urandom_range(0, 2));
      li = 4'($urandom_range(0, 15));
      wo = 2'($urandom_range(0, 3));
      w  = {t, li, wo};
      op = $urandom_range(0, 99);
      if (op < 45)      do_req(1'b0, w, 32'h0, 4'h0);
      else if (op < 80) do_req(1'b0, w, $urandom, 4'($urandom_range(1, 15)));
      else if (op < 93) do_req(1'b1, w, 32'h0, 4'h0);
      else              do_req(1'b1, w, 32'h0, 4'($urandom_range(1, 15)));
    end

    repeat (5) @(negedge clk);
    check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);
    check("mem_queue_drained", 64'(exp_mem_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
